register_file_ext: RTL

Parametrised next-generation register file for the ARM pipeline. It provides three combinational read ports, including the third operand needed for store-register instructions. It has two prioritised write ports: one for writeback and one for base-register update. Optional same-cycle write-to-read bypass is built in. A per-register busy scoreboard lets the decode stage detect RAW hazards without a separate hazard unit.

---
 rtl/register_file_ext.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/register_file_ext.sv
// -----------------------------------------------------------------------------
// register_file_ext
//
// Register file for the ARM pipeline.
//
// It provides:
//   - three combinational read ports. The third port supplies the store-data
//     operand for STR-type instructions.
//   - two write ports with fixed priority:
//       port 0 = writeback (wins any collision)
//       port 1 = base-register update
//   - optional same-cycle forwarding of write data to the read ports.
//   - a per-register busy scoreboard. Decode can detect RAW hazards with it
//     directly.
//
// Parameters:
//   DATA_W      register width in bits
//   ADDR_W      register address width; NUM_REGS = 2**ADDR_W
//   RESET_INDEX 1: register i resets to i (truncated); 0: all reset to 0
//   BYPASS      1: reads/busy see same-cycle writes; 0: stored state only
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rd_addrN / rd_dataN       read ports 1..3 (zero latency)
//   busyN                     scoreboard bit for rd_addrN. It is masked when
//                             the value is being forwarded from port 0.
//   wr_en0/wr_addr0/wr_data0  write port 0 (writeback). It also clears busy.
//   wr_en1/wr_addr1/wr_data1  write port 1 (base update). It never clears busy.
//   issue_en/issue_dest       mark issue_dest as pending (busy)
//   busy_vec                  raw scoreboard, bit i = register i pending
// -----------------------------------------------------------------------------
module register_file_ext #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter bit RESET_INDEX = 1'b1,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic [ADDR_W-1:0]      rd_addr1,
  input  logic [ADDR_W-1:0]      rd_addr2,
  input  logic [ADDR_W-1:0]      rd_addr3,
  output logic [DATA_W-1:0]      rd_data1,
  output logic [DATA_W-1:0]      rd_data2,
  output logic [DATA_W-1:0]      rd_data3,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   busy3,

  input  logic                   wr_en0,
  input  logic [ADDR_W-1:0]      wr_addr0,
  input  logic [DATA_W-1:0]      wr_data0,
  input  logic                   wr_en1,
  input  logic [ADDR_W-1:0]      wr_addr1,
  input  logic [DATA_W-1:0]      wr_data1,

  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      issue_dest,
  output logic [2**ADDR_W-1:0]   busy_vec
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int NUM_RD   = 3;

  // Flat view of the storage. Each register owns its flop in its generate
  // block; this array is only the read-mux source.
  logic [DATA_W-1:0]   reg_view [NUM_REGS];

  // One-hot write decodes.
  //   wr_sel1 already excludes the collision case, so at most one port
  //   targets a given register in a cycle.
  logic [NUM_REGS-1:0] wr_sel0;
  logic [NUM_REGS-1:0] wr_sel1;

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // ---------------------------------------------------------------------------
  // Storage and scoreboard, one slice per register
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX     = ADDR_W'(gi);
      localparam logic [DATA_W-1:0] RST_VAL = RESET_INDEX ? DATA_W'(gi) : '0;

      logic [DATA_W-1:0] data_reg;
      logic              issue_hit;

      assign wr_sel0[gi] = wr_en0 && (wr_addr0 == IDX);
      // Port 1 is dropped when port 0 writes the same address. For this
      // register that condition is exactly "port 0 selects it".
      assign wr_sel1[gi] = wr_en1 && (wr_addr1 == IDX) && !wr_sel0[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= RST_VAL;
        end else if (wr_sel0[gi]) begin
          data_reg <= wr_data0;
        end else if (wr_sel1[gi]) begin
          data_reg <= wr_data1;
        end
      end

      assign reg_view[gi] = data_reg;

      // Only writeback (port 0) retires a producer.
      // Set beats clear when both happen in one cycle, because the new issue
      // is the producer that is still outstanding.
      assign issue_hit     = issue_en && (issue_dest == IDX);
      assign busy_next[gi] = issue_hit || (busy_reg[gi] && !wr_sel0[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

  // ---------------------------------------------------------------------------
  // Read ports.
  // Each port forwards independently, with the same priority as the writes:
  // port 0 first, then port 1.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              busy;
      logic              hit0;
      logic              hit1;

      assign addr = (gi == 0) ? rd_addr1 :
                    (gi == 1) ? rd_addr2 : rd_addr3;

      always_comb begin
        hit0 = BYPASS && wr_en0 && (wr_addr0 == addr);
        hit1 = BYPASS && wr_en1 && (wr_addr1 == addr);
        data = reg_view[addr];
        if (hit0) begin
          data = wr_data0;
        end else if (hit1) begin
          data = wr_data1;
        end
        // A value forwarded from writeback is ready now, so do not report it
        // as a hazard. Port 1 forwarding does not retire a producer, so it
        // leaves busy untouched.
        busy = busy_reg[addr] && !hit0;
      end
    end
  endgenerate

  assign rd_data1 = g_rd[0].data;
  assign rd_data2 = g_rd[1].data;
  assign rd_data3 = g_rd[2].data;
  assign busy1    = g_rd[0].busy;
  assign busy2    = g_rd[1].busy;
  assign busy3    = g_rd[2].busy;

endmodule
